// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port register file.
//
// Purpose:
//   XLEN x NREGS storage with NRD combinational read ports and NWR write
//   ports. After reset a sequential clear engine writes zero to every entry
//   (one per clock) so the storage array itself carries no reset. Optional
//   hardwired-zero register 0 and optional same-cycle write-to-read bypass.
//   Colliding writes resolve to the highest-index enabled port.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst_n          asynchronous active-low reset (restarts the clear)
//   read_addr      NRD*AW    read addresses, port k at [k*AW +: AW]
//   read_data      NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
//   write_enable   NWR       per-port write enable
//   write_addr     NWR*AW    write addresses, port j at [j*AW +: AW]
//   write_data     NWR*XLEN  write data, port j at [j*XLEN +: XLEN]
//   init_busy      high while the clear engine runs; writes ignored
//   write_conflict registered pulse: previous cycle had two or more enabled
//                  write ports on the same writable address
module regfile_mp #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 64,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   read_addr,
  output logic [NRD*XLEN-1:0] read_data,
  input  logic [NWR-1:0]      write_enable,
  input  logic [NWR*AW-1:0]   write_addr,
  input  logic [NWR*XLEN-1:0] write_data,
  output logic                init_busy,
  output logic                write_conflict
);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   clr_cnt_reg, clr_cnt_next;
  logic            conflict_reg, conflict_next;
  logic [XLEN-1:0] mem [NREGS];
  logic [NWR-1:0]  wr_valid;

  // Address 0 is read-only zero when ZERO_REG is set.
  function automatic logic is_writable(input logic [AW-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  // A port only counts as writing when enabled, in READY, and aimed at a
  // writable address. Everything downstream (array, bypass, conflict) uses this.
  for (genvar gi = 0; gi < NWR; gi++) begin : g_wr_valid
    assign wr_valid[gi] = write_enable[gi] && (state_reg == ST_READY) &&
                          is_writable(write_addr[gi*AW +: AW]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_INIT;
      clr_cnt_reg  <= '0;
      conflict_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_cnt_reg  <= clr_cnt_next;
      conflict_reg <= conflict_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_cnt_next  = clr_cnt_reg;
    conflict_next = 1'b0;
    case (state_reg)
      ST_INIT: begin
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == AW'(NREGS - 1)) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        // wr_valid is already gated by READY, so INIT can never flag a conflict.
        for (int i = 0; i < NWR; i++) begin
          for (int j = i + 1; j < NWR; j++) begin
            if (wr_valid[i] && wr_valid[j] &&
                (write_addr[i*AW +: AW] == write_addr[j*AW +: AW])) begin
              conflict_next = 1'b1;
            end
          end
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  // Storage: no reset; the clear engine zeroes it. Ascending port order means
  // the highest-index port's assignment lands last and wins on a collision.
  always_ff @(posedge clk) begin
    if (state_reg == ST_INIT) begin
      mem[clr_cnt_reg] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_valid[j]) begin
          mem[write_addr[j*AW +: AW]] <= write_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd_val;

    assign ra = read_addr[gi*AW +: AW];

    always_comb begin
      rd_val = mem[ra];
      if (BYPASS != 0) begin
        // Ascending scan so the highest matching port is the one forwarded.
        for (int j = 0; j < NWR; j++) begin
          if (wr_valid[j] && (write_addr[j*AW +: AW] == ra)) begin
            rd_val = write_data[j*XLEN +: XLEN];
          end
        end
      end
      // Zero register and INIT override everything, bypass included.
      if ((state_reg != ST_READY) || ((ZERO_REG != 0) && (ra == '0))) begin
        rd_val = '0;
      end
    end

    assign read_data[gi*XLEN +: XLEN] = rd_val;
  end

  assign init_busy      = (state_reg == ST_INIT);
  assign write_conflict = conflict_reg;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int XLEN  = 64;
  localparam int NREGS = 64;
  localparam int AW    = 6;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NRD*AW-1:0]   read_addr;
  logic [NWR-1:0]      write_enable;
  logic [NWR*AW-1:0]   write_addr;
  logic [NWR*XLEN-1:0] write_data;
  logic [NRD*XLEN-1:0] rd_byp, rd_nob;
  logic                busy_byp, busy_nob, conf_byp, conf_nob;

  int checks   = 0;
  int failures = 0;

  // Bypass-enabled instance and bypass-disabled instance share all inputs.
  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
               .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .read_addr(read_addr), .read_data(rd_byp),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .init_busy(busy_byp), .write_conflict(conf_byp));

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
               .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .read_addr(read_addr), .read_data(rd_nob),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .init_busy(busy_nob), .write_conflict(conf_nob));

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] model_mem [NREGS];
  int              init_left = NREGS;   // clear edges still to come
  logic            exp_conf  = 1'b0;
  int              wcnt [NREGS];

  function automatic logic [AW-1:0] wa(input int j);
    return write_addr[j*AW +: AW];
  endfunction

  function automatic logic [XLEN-1:0] wd(input int j);
    return write_data[j*XLEN +: XLEN];
  endfunction

  function automatic logic model_busy();
    return (!rst_n) || (init_left > 0);
  endfunction

  function automatic logic [XLEN-1:0] exp_read(input bit byp, input logic [AW-1:0] a);
    if (model_busy()) return '0;
    if (a == 0) return '0;
    if (byp) begin
      for (int j = NWR - 1; j >= 0; j--) begin
        if (write_enable[j] && wa(j) == a) return wd(j);
      end
    end
    return model_mem[a];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      init_left = NREGS;
      exp_conf  = 1'b0;
    end else if (init_left > 0) begin
      model_mem[NREGS - init_left] = '0;
      init_left = init_left - 1;
      exp_conf  = 1'b0;
    end else begin
      for (int a = 0; a < NREGS; a++) wcnt[a] = 0;
      for (int j = 0; j < NWR; j++) begin
        if (write_enable[j] && wa(j) != 0) wcnt[wa(j)] = wcnt[wa(j)] + 1;
      end
      exp_conf = 1'b0;
      for (int a = 1; a < NREGS; a++) if (wcnt[a] > 1) exp_conf = 1'b1;
      // Highest-index enabled port wins: scan downward, first hit per address.
      for (int a = 1; a < NREGS; a++) begin
        for (int j = NWR - 1; j >= 0; j--) begin
          if (write_enable[j] && wa(j) == a) begin
            model_mem[a] = wd(j);
            break;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("busy_byp", 64'(busy_byp), 64'(model_busy()));
    chk("busy_nob", 64'(busy_nob), 64'(model_busy()));
    chk("conf_byp", 64'(conf_byp), 64'(rst_n ? exp_conf : 1'b0));
    chk("conf_nob", 64'(conf_nob), 64'(rst_n ? exp_conf : 1'b0));
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("rd_byp%0d@%0d", k, read_addr[k*AW +: AW]),
          rd_byp[k*XLEN +: XLEN], exp_read(1'b1, read_addr[k*AW +: AW]));
      chk($sformatf("rd_nob%0d@%0d", k, read_addr[k*AW +: AW]),
          rd_nob[k*XLEN +: XLEN], exp_read(1'b0, read_addr[k*AW +: AW]));
    end
  end

  // ---------------- stimulus and literal pins ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (n < 200) begin
      step();
      n++;
      if (!busy_byp) break;
    end
    chk(name, 64'(n), 64'd64);
  endtask

  task automatic sweep_zero(input string name);
    write_enable = '0;
    for (int a = 0; a < NREGS; a++) begin
      read_addr = {AW'(a), AW'(a)};
      #1;
      chk($sformatf("%s_a%0d", name, a), rd_nob[0 +: XLEN], 64'd0);
    end
    step();
  endtask

  initial begin
    rst_n        = 1'b0;
    read_addr    = '0;
    write_enable = '0;
    write_addr   = '0;
    write_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Writes held active through INIT must be ignored.
    write_enable = 2'b11;
    write_addr   = {AW'(9), AW'(5)};
    write_data   = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    wait_init("init_busy_len");
    sweep_zero("clear");

    // Basic write/read: old value without bypass, new value with bypass.
    write_enable = 2'b01;
    write_addr   = {AW'(0), AW'(5)};
    write_data   = {64'd0, 64'hDEAD_BEEF_0000_0001};
    read_addr    = {AW'(5), AW'(0)};
    #1;
    chk("nob_old", rd_nob[XLEN +: XLEN], 64'd0);
    chk("byp_new", rd_byp[XLEN +: XLEN], 64'hDEAD_BEEF_0000_0001);
    step();
    write_enable = '0;
    #1;
    chk("nob_new", rd_nob[XLEN +: XLEN], 64'hDEAD_BEEF_0000_0001);

    // Bypass on both read ports from write port 1.
    write_enable = 2'b10;
    write_addr   = {AW'(33), AW'(0)};
    write_data   = {64'h1234, 64'd0};
    read_addr    = {AW'(33), AW'(33)};
    #1;
    chk("byp_p0", rd_byp[0 +: XLEN], 64'h1234);
    chk("byp_p1", rd_byp[XLEN +: XLEN], 64'h1234);
    step();

    // Collision on addr 7: port 1 wins, one-cycle conflict pulse.
    write_enable = 2'b11;
    write_addr   = {AW'(7), AW'(7)};
    write_data   = {64'hBBBB, 64'hAAAA};
    step();
    write_enable = '0;
    read_addr    = {AW'(0), AW'(7)};
    #1;
    chk("coll_val", rd_nob[0 +: XLEN], 64'hBBBB);
    chk("coll_pulse", 64'(conf_byp), 64'd1);
    step();
    chk("coll_clear", 64'(conf_byp), 64'd0);

    // Collision on addr 0 never flags.
    write_enable = 2'b11;
    write_addr   = '0;
    write_data   = {64'h1, 64'h2};
    step();
    write_enable = '0;
    #1;
    chk("coll_zero", 64'(conf_byp), 64'd0);

    // Zero register vs f0.
    write_enable = 2'b01;
    write_addr   = {AW'(0), AW'(0)};
    write_data   = {64'd0, 64'hFFFF};
    read_addr    = '0;
    #1;
    chk("zero_byp", rd_byp[0 +: XLEN], 64'd0);
    step();
    write_enable = '0;
    #1;
    chk("zero_after", rd_nob[0 +: XLEN], 64'd0);
    write_enable = 2'b01;
    write_addr   = {AW'(0), AW'(32)};
    step();
    write_enable = '0;
    read_addr    = {AW'(0), AW'(32)};
    #1;
    chk("f0_stored", rd_nob[0 +: XLEN], 64'hFFFF);

    // Fill 1..63, then reset mid-operation.
    for (int a = 1; a < NREGS; a++) begin
      write_enable = 2'b01;
      write_addr   = {AW'(0), AW'(a)};
      write_data   = {64'd0, 64'(a * 3 + 1)};
      step();
    end
    write_enable = '0;
    read_addr    = {AW'(0), AW'(63)};
    #1;
    chk("fill_63", rd_nob[0 +: XLEN], 64'd190);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_init("reinit_busy_len");
    sweep_zero("reclear");

    // Randomized phase; narrow address range half the time for collisions.
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      write_enable = NWR'($urandom);
      for (int j = 0; j < NWR; j++) begin
        write_addr[j*AW +: AW]   = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        write_data[j*XLEN +: XLEN] = {$urandom, $urandom};
      end
      for (int k = 0; k < NRD; k++) begin
        read_addr[k*AW +: AW] = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      end
      step();
    end
    rst_n = 1'b1;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer/FP register file; successor to the fixed 64x64, 2-read/1-write file.
- Configurable width, depth, read-port count and write-port count.
- Additions: hardwired-zero register 0, optional write-to-read bypass, deterministic write-port priority, and a sequential post-reset clear engine so the array needs no per-bit async reset.
- Sits between decode (read addresses) and writeback (write ports) in the core pipeline.

Parameters:
- XLEN, 64, data width per register
- NREGS, 64, number of registers; indices 0..31 are x0..x31, 32..63 are f0..f31 at default; must be a power of two and >= 2
- AW, $clog2(NREGS), address width (derived)
- NRD, 2, number of read ports (>= 1)
- NWR, 2, number of write ports (>= 1)
- ZERO_REG, 1, 1 = index 0 reads as zero and ignores writes
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- read_addr  in  NRD*AW  read addresses; port k at bits [k*AW +: AW]
- read_data  out  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN]
- write_enable  in  NWR  per-port write enable
- write_addr  in  NWR*AW  write addresses; port j at bits [j*AW +: AW]
- write_data  in  NWR*XLEN  write data; port j at bits [j*XLEN +: XLEN]
- init_busy  out  1  high while the clear engine runs; writes are ignored while high
- write_conflict  out  1  registered pulse: in the previous cycle, two or more enabled write ports targeted the same writable address

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low (rst_n).
- rst_n low:
  - FSM forced to INIT; clear counter = 0; init_busy = 1; write_conflict = 0.
  - Array contents are not reset directly.
- FSM state INIT:
  - Each rising edge writes 0 to reg[counter], then increments counter.
  - When counter == NREGS-1 is written, next state is READY and init_busy falls at that same edge.
  - init_busy is therefore high for exactly NREGS rising edges after rst_n deasserts.
  - All write_enable bits are ignored.
  - All read_data outputs = 0, no bypass.
- FSM state READY:
  - Normal operation; stays in READY until rst_n asserts.
  - rst_n asserting mid-operation returns to INIT immediately, from any state, and restarts the clear from 0.
- Reads:
  - Combinational, zero latency.
  - read_data[k] = reg[read_addr[k]], with the overrides below.
- ZERO_REG = 1:
  - A read of address 0 returns 0.
  - A write to address 0 is dropped and never counts toward write_conflict.
- Writes:
  - Port j writes on the rising edge when write_enable[j] = 1 in READY.
  - Same-address collision: the highest-index enabled port wins; lower ports are discarded.
- write_conflict:
  - Set on the edge after a cycle with any collision on a writable address.
  - Cleared on the next edge unless the collision repeats.
  - Forced to 0 in INIT.
- BYPASS = 1, in READY:
  - If any enabled write port targets read_addr[k] (a writable address), read_data[k] returns the winning port's write_data in that same cycle.
  - The ZERO_REG override takes precedence over bypass.
- BYPASS = 0:
  - Read returns the pre-edge stored value; the new value is visible from the next cycle.
- Read ports are independent: any number of ports may read the same address.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Test Plan:
- Reset and clear: pulse rst_n low, hold write_enable = 1 during INIT -> init_busy high for exactly 64 cycles. After it falls, all 64 addresses read 0 and no INIT-time write landed.
- Basic write/read, BYPASS = 0: write 0xDEADBEEF_00000001 to addr 5 on port 0 -> read port 1 at addr 5 shows the old value in the write cycle and the new value on the next cycle.
- Bypass, BYPASS = 1: same cycle, port 1 writes 0x1234 to addr 33 and read ports 0 and 1 both address 33 -> both return 0x1234 combinationally.
- Collision: ports 0 and 1 both write addr 7, with 0xAAAA and 0xBBBB -> addr 7 holds 0xBBBB. write_conflict = 1 for exactly one cycle after. A collision on addr 0 -> write_conflict stays 0.
- Zero register: write 0xFFFF to addr 0 -> reads of addr 0 return 0, including during the write cycle with bypass enabled. The same write to addr 32 (f0) is stored.
- Reset mid-operation: fill regs 1..63 with nonzero values, assert rst_n low for 1 cycle, then release -> init_busy high for 64 cycles, then all registers read 0.
